// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in, instruction memory write port out
interface imem_loader_if #(
  parameter int PC_W  = 8,
  parameter int INS_W = 32
);
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             im_wr_en;
  logic [PC_W-1:0]  im_wr_addr;
  logic [INS_W-1:0] im_wr_data;

  // The loader owns the memory write port and sinks the byte stream.
  modport master (
    input  rx_valid, rx_data,
    output rx_ready, im_wr_en, im_wr_addr, im_wr_data
  );

  // Byte source and instruction memory side.
  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, im_wr_en, im_wr_addr, im_wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to instruction memory writer with checksum gate
module imem_loader #(
  parameter int PC_W  = 8,
  parameter int INS_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          core_reset_n,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  // Largest image that fits: one word per 4-byte slot.
  localparam logic [31:0] CAP = 32'd1 << (PC_W - 2);

  state_t           state_q, state_d;
  logic [7:0]       len_q;
  logic [8:0]       count_q;
  logic [PC_W-1:0]  addr_q;
  logic [1:0]       byte_idx_q;
  logic [23:0]      word_q;
  logic [7:0]       csum_q;
  logic [PC_W-1:0]  wr_addr_q;
  logic [INS_W-1:0] wr_data_q;

  logic xfer;
  logic load_start;
  logic last_word;
  logic len_too_big;

  assign xfer        = bus.rx_valid && bus.rx_ready;
  assign load_start  = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign last_word   = (count_q + 9'd1) == {1'b0, len_q};
  assign len_too_big = {24'd0, bus.rx_data} > CAP;

  // State register; reset parks the loader in IDLE with the core held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: frame walk LEN -> (DATA/WRITE)* -> CSUM -> DONE/ERR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN;
      S_LEN: begin
        if (xfer) begin
          if (bus.rx_data == 8'd0) state_d = S_CSUM;
          else if (len_too_big)    state_d = S_ERR;
          else                     state_d = S_DATA;
        end
      end
      S_DATA:  if (xfer && byte_idx_q == 2'd3) state_d = S_WRITE;
      S_WRITE: state_d = last_word ? S_CSUM : S_DATA;
      S_CSUM: begin
        if (xfer) state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; the core only runs after a verified load.
  always_comb begin
    bus.rx_ready = 1'b0;
    bus.im_wr_en = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    core_reset_n = 1'b0;
    case (state_q)
      S_LEN, S_DATA, S_CSUM: bus.rx_ready = 1'b1;
      S_WRITE:               bus.im_wr_en = 1'b1;
      S_DONE: begin
        done         = 1'b1;
        core_reset_n = 1'b1;
      end
      S_ERR:                 error = 1'b1;
      default: ;
    endcase
  end

  assign bus.im_wr_addr = wr_addr_q;
  assign bus.im_wr_data = wr_data_q;

  // Datapath: byte packing, checksum, word/address counters, write-port capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q      <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      if (load_start) begin
        addr_q     <= '0;
        byte_idx_q <= '0;
        csum_q     <= '0;
        count_q    <= '0;
      end
      if (state_q == S_LEN && xfer) len_q <= bus.rx_data;
      if (state_q == S_DATA && xfer) begin
        byte_idx_q <= byte_idx_q + 2'd1;
        csum_q     <= csum_q ^ bus.rx_data;
        case (byte_idx_q)
          2'd0: word_q[7:0]   <= bus.rx_data;
          2'd1: word_q[15:8]  <= bus.rx_data;
          2'd2: word_q[23:16] <= bus.rx_data;
          default: begin
            // Last byte goes straight into the write port so WRITE follows the edge.
            wr_data_q <= {bus.rx_data, word_q};
            wr_addr_q <= addr_q;
          end
        endcase
      end
      if (state_q == S_WRITE) begin
        count_q <= count_q + 9'd1;
        // Skip the step after the final word so a full image never wraps to 0.
        if (!last_word) addr_q <= addr_q + PC_W'(4);
      end
    end
  end

endmodule
